centroid_ctrl: RTL

CENTROID_CTRL -- requirements
Module: centroid_ctrl

---
 rtl/centroid_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/centroid_ctrl.sv
// centroid_ctrl: drives three external accumulators (sum of x, sum of y, pixel
// count) from a masked video stream and, at each frame boundary, divides the
// ended frame's sums to produce the object centroid (cx, cy).
// Handshake: no ready path; c_valid, no_obj and overrun are single-cycle
// strobes, and cx/cy hold their values until the next c_valid.
module centroid_ctrl #(
    parameter int XW = 11,
    parameter int SW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de,
    input  logic          v_sync,
    input  logic          mask,
    input  logic [SW-1:0] sum_x,
    input  logic [SW-1:0] sum_y,
    input  logic [SW-1:0] sum_m,
    output logic          acc_ce,
    output logic          acc_clr,
    output logic [XW-1:0] x_pos,
    output logic [XW-1:0] y_pos,
    output logic [XW-1:0] cx,
    output logic [XW-1:0] cy,
    output logic          c_valid,
    output logic          no_obj,
    output logic          overrun,
    output logic          busy,
    output logic [2:0]    dbg_state
);

    localparam int CW = $clog2(SW);

    typedef enum logic [2:0] {IDLE, ACC, DIV_X, DIV_Y, DONE} state_t;

    state_t        state, state_nxt;
    logic          vs_q, de_q, bnd, rise;
    logic [XW-1:0] x_cnt, y_cnt;
    // quo doubles as the x-sum snapshot: it is loaded with sum_x at the
    // boundary and shifted into the quotient during DIV_X.
    logic [SW-1:0] snap_y, snap_m, quo, rem, qx;
    logic [CW-1:0] bit_cnt;
    logic          last_bit;

    // one restoring-division step
    logic [SW:0]   r_sh, r_sub;
    logic          r_ge;
    logic [SW-1:0] q_step, r_step;

    assign rise      = v_sync & ~vs_q;
    assign acc_clr   = bnd;
    assign last_bit  = (bit_cnt == CW'(SW - 1));
    assign dbg_state = state;

    function automatic logic [XW-1:0] clamp(input logic [SW-1:0] q);
        if (|q[SW-1:XW]) return '1;
        return q[XW-1:0];
    endfunction

    // v_sync edge register, boundary strobe and the one-cycle pixel pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            bnd    <= 1'b0;
            acc_ce <= 1'b0;
            x_pos  <= '0;
            y_pos  <= '0;
        end else begin
            vs_q   <= v_sync;
            de_q   <= de;
            bnd    <= rise;
            acc_ce <= de & mask & ~rise;   // keeps acc_ce low in the boundary cycle
            x_pos  <= x_cnt;
            y_pos  <= y_cnt;
        end
    end

    // pixel coordinate counters, wrapping modulo 2^XW
    always_ff @(posedge clk) begin
        if (rst || bnd) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (de) begin
            x_cnt <= x_cnt + XW'(1);
        end else if (de_q) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + XW'(1);
        end
    end

    // divider step: shift in the next dividend bit and try to subtract
    always_comb begin
        r_sh   = {rem, quo[SW-1]};
        r_sub  = r_sh - {1'b0, snap_m};
        r_ge   = ~r_sub[SW];
        q_step = {quo[SW-2:0], r_ge};
        r_step = r_ge ? r_sub[SW-1:0] : r_sh[SW-1:0];
    end

    // control state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and status strobes
    always_comb begin
        state_nxt = state;
        c_valid   = 1'b0;
        no_obj    = 1'b0;
        overrun   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: if (bnd) state_nxt = ACC;
            ACC: begin
                if (bnd) begin
                    if (sum_m == '0) no_obj = 1'b1;
                    else             state_nxt = DIV_X;
                end
            end
            DIV_X: begin
                busy    = 1'b1;
                overrun = bnd;
                if (last_bit) state_nxt = DIV_Y;
            end
            DIV_Y: begin
                busy    = 1'b1;
                overrun = bnd;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                c_valid   = 1'b1;
                overrun   = bnd;
                state_nxt = ACC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // snapshot, divider registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_y  <= '0;
            snap_m  <= '0;
            quo     <= '0;
            rem     <= '0;
            qx      <= '0;
            bit_cnt <= '0;
            cx      <= '0;
            cy      <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (bnd) begin
                        quo     <= sum_x;
                        snap_y  <= sum_y;
                        snap_m  <= sum_m;
                        rem     <= '0;
                        bit_cnt <= '0;
                    end
                end
                DIV_X: begin
                    if (last_bit) begin
                        qx      <= q_step;
                        quo     <= snap_y;
                        rem     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        quo     <= q_step;
                        rem     <= r_step;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                DIV_Y: begin
                    quo     <= q_step;
                    rem     <= r_step;
                    bit_cnt <= bit_cnt + CW'(1);
                    // results are in place for the DONE cycle
                    if (last_bit) begin
                        cx <= clamp(qx);
                        cy <= clamp(q_step);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
